fsm_cursor_painter: RTL and testbench
=====================================

// Module: fsm_cursor_painter
// PURPOSE
//  Game-logic FSM for the VGA path. Moves a 1-pixel cursor over a GRID_W x GRID_H framebuffer
//  under 4 direction buttons and issues single-cycle pixel writes to the framebuffer port.
//  Clears the framebuffer after reset. Paced by an internal clock-enable tick, not a derived clock.
//  Sits between the button inputs and the write port of the dual-port VGA pixel memory.
// PARAMETERS
//  AW        8         framebuffer address width; must be >= clog2(GRID_W*GRID_H)
//  DW        3         pixel data width (RGB111)
//  GRID_W    16        grid width in pixels
//  GRID_H    16        grid height in pixels
//  TICK_DIV  5000000   clk cycles per game tick (10 Hz at 50 MHz); must be >= 4
//  BG_COLOR  3'b000    background / erase colour
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 synchronous reset, active-high
//  btn_right    in   1                 async button, held = move +x
//  btn_left     in   1                 async button, held = move -x
//  btn_down     in   1                 async button, held = move +y
//  btn_up       in   1                 async button, held = move -y
//  color_in     in   DW                cursor colour, sampled when a move is accepted
//  mem_px_addr  out  AW                pixel address = y*GRID_W + x
//  mem_px_data  out  DW                pixel data
//  px_wr        out  1                 write strobe, 1-cycle pulse per pixel
//  cursor_x     out  clog2(GRID_W)     current cursor column
//  cursor_y     out  clog2(GRID_H)     current cursor row
//  busy         out  1                 high in every state except IDLE
// BEHAVIOUR
//  - Reset, all outputs registered: px_wr=0, mem_px_addr=0, mem_px_data=0, cursor=(0,0),
//    busy=1, state=CLEAR, tick counter=0, clear counter=0, synchronisers=0.
//  - Buttons pass through 2-FF synchronisers (2 cycles latency); only synced values are used.
//  - Tick: counter 0..TICK_DIV-1; tick=1 for the one cycle where counter==TICK_DIV-1.
//    Counter runs in all states.
//  - CLEAR: one write per cycle, addr 0..GRID_W*GRID_H-1, data=BG_COLOR, then -> DRAW at (0,0).
//  - IDLE: on tick, at least one synced button held -> latch color_in, compute target -> ERASE.
//    Priority right > left > down > up; only one axis moves per tick.
//    Tick with no button held: stay IDLE, no write.
//  - Wrap-around: x=GRID_W-1 +right -> 0; x=0 +left -> GRID_W-1; same rule for y with GRID_H.
//  - Latency: tick in IDLE at cycle T -> px_wr=1 at T+1 (old addr, ERASE) and at T+2 (new addr,
//    latched colour, DRAW); cursor_x/y take the new value at T+2; IDLE at T+3.
//  - A tick arriving outside IDLE is dropped, not queued.
//  - Addresses >= GRID_W*GRID_H are never emitted. px_wr=0 in IDLE.
//  - rst asserted in any state, including mid-CLEAR or mid-move: abort and reload reset values on the
//    next edge; CLEAR restarts from address 0.
// CONFIGURATION
//  FSM_TRAIL_EN undefined: ERASE writes BG_COLOR at the old position (single moving dot).
//  FSM_TRAIL_EN defined: ERASE is skipped; old pixel keeps its colour (paint/trail mode).
//    Latency is then: tick at T -> single DRAW write at T+1; cursor updates at T+1; IDLE at T+2.
// TESTING
//  (GRID_W=GRID_H=4, TICK_DIV=4, AW=4)
//  1 rst 1 cycle -> 16 consecutive writes addr 0..15 data 000, then write addr 0 data color_in;
//    busy falls afterwards.
//  2 btn_right held, color_in=111, cursor (0,0) -> writes (addr0,000) then (addr1,111);
//    cursor_x=1 at T+2.
//  3 cursor (3,2), btn_right held 1 tick -> new addr 8 (x wraps to 0, y=2); cursor (0,2).
//  4 btn_right+btn_left+btn_up held together -> only +x move; btn_up alone at y=0 -> y=3.
//  5 rst pulsed mid-CLEAR at addr 7 -> next write is addr 0; full 16-write clear repeats.
//  6 FSM_TRAIL_EN defined, 3 right ticks from (0,0) -> 3 writes only, addrs 1,2,3; no BG writes.

Source files
------------

// File: rtl/fsm_cursor_painter.sv
// fsm_cursor_painter: game-logic FSM that moves a 1-pixel cursor over a GRID_W x GRID_H
// framebuffer under four direction buttons and issues single-cycle pixel writes.
// After reset it clears the framebuffer, then draws the cursor at (0,0).
// Moves are paced by an internal clock-enable tick every TICK_DIV cycles.
//
// Optional feature macro: FSM_TRAIL_EN
//   undefined : each move erases the old pixel (BG_COLOR), then draws the new one.
//   defined   : the erase is skipped, so the old pixel keeps its colour (paint mode).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   btn_right/left/down/up        asynchronous direction buttons, held = move
//   color_in     [DW-1:0]         cursor colour, sampled when a move is accepted
//   mem_px_addr  [AW-1:0]         pixel address = y*GRID_W + x
//   mem_px_data  [DW-1:0]         pixel data
//   px_wr                         write strobe, one-cycle pulse per pixel
//   cursor_x/cursor_y             current cursor column/row
//   busy                          high in every state except IDLE
module fsm_cursor_painter #(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   DW       = 3,
    parameter int unsigned   GRID_W   = 16,
    parameter int unsigned   GRID_H   = 16,
    parameter int unsigned   TICK_DIV = 5000000,
    parameter logic [DW-1:0] BG_COLOR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_right,
    input  logic                      btn_left,
    input  logic                      btn_down,
    input  logic                      btn_up,
    input  logic [DW-1:0]             color_in,
    output logic [AW-1:0]             mem_px_addr,
    output logic [DW-1:0]             mem_px_data,
    output logic                      px_wr,
    output logic [$clog2(GRID_W)-1:0] cursor_x,
    output logic [$clog2(GRID_H)-1:0] cursor_y,
    output logic                      busy
);

    localparam int unsigned XW   = $clog2(GRID_W);
    localparam int unsigned YW   = $clog2(GRID_H);
    localparam int unsigned TW   = $clog2(TICK_DIV);
    localparam int unsigned NPIX = GRID_W * GRID_H;
    localparam int unsigned CW   = AW + 1;  // clear counter must be able to hold NPIX

    typedef enum logic [1:0] {
        S_CLEAR,
        S_DRAW,
        S_IDLE,
        S_ERASE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [3:0]      sync1_q, sync1_d;   // {right, left, down, up}
    logic [3:0]      sync2_q, sync2_d;
    logic [DW-1:0]   color_q, color_d;
    logic [XW-1:0]   tgt_x_q, tgt_x_d;
    logic [YW-1:0]   tgt_y_q, tgt_y_d;
    logic [XW-1:0]   cur_x_q, cur_x_d;
    logic [YW-1:0]   cur_y_q, cur_y_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            wr_q, wr_d;
    logic            busy_q, busy_d;

    logic            tick_c;
    logic [XW-1:0]   move_x_c;
    logic [YW-1:0]   move_y_c;

    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(32'(y) * GRID_W + 32'(x));
    endfunction

    assign tick_c = (tick_cnt_q == TW'(TICK_DIV - 1));

    // Target position from synced buttons: right > left > down > up, one axis per tick, wrapping.
    always_comb begin
        move_x_c = cur_x_q;
        move_y_c = cur_y_q;
        if (sync2_q[3]) begin
            move_x_c = (cur_x_q == XW'(GRID_W - 1)) ? '0 : cur_x_q + XW'(1);
        end else if (sync2_q[2]) begin
            move_x_c = (cur_x_q == '0) ? XW'(GRID_W - 1) : cur_x_q - XW'(1);
        end else if (sync2_q[1]) begin
            move_y_c = (cur_y_q == YW'(GRID_H - 1)) ? '0 : cur_y_q + YW'(1);
        end else if (sync2_q[0]) begin
            move_y_c = (cur_y_q == '0) ? YW'(GRID_H - 1) : cur_y_q - YW'(1);
        end
    end

    // Next state; every output is computed for the state being entered, then registered.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
        clr_cnt_d  = clr_cnt_q;
        sync1_d    = {btn_right, btn_left, btn_down, btn_up};
        sync2_d    = sync1_q;
        color_d    = color_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;

        case (state_q)
            S_CLEAR: begin
                if (clr_cnt_q < CW'(NPIX)) begin
                    wr_d      = 1'b1;
                    addr_d    = AW'(clr_cnt_q);
                    data_d    = BG_COLOR;
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end else begin
                    state_d = S_DRAW;
                    wr_d    = 1'b1;
                    addr_d  = pix_addr(cur_x_q, cur_y_q);
                    data_d  = color_in;
                    color_d = color_in;
                end
            end
            S_IDLE: begin
                if (tick_c && (|sync2_q)) begin
                    color_d = color_in;
                    wr_d    = 1'b1;
`ifdef FSM_TRAIL_EN
                    state_d = S_DRAW;
                    addr_d  = pix_addr(move_x_c, move_y_c);
                    data_d  = color_in;
                    cur_x_d = move_x_c;
                    cur_y_d = move_y_c;
`else
                    state_d = S_ERASE;
                    addr_d  = pix_addr(cur_x_q, cur_y_q);
                    data_d  = BG_COLOR;
                    tgt_x_d = move_x_c;
                    tgt_y_d = move_y_c;
`endif
                end
            end
            S_ERASE: begin
                state_d = S_DRAW;
                wr_d    = 1'b1;
                addr_d  = pix_addr(tgt_x_q, tgt_y_q);
                data_d  = color_q;
                cur_x_d = tgt_x_q;
                cur_y_d = tgt_y_q;
            end
            S_DRAW: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            tick_cnt_q <= '0;
            clr_cnt_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            color_q    <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            color_q    <= color_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign px_wr       = wr_q;
    assign cursor_x    = cur_x_q;
    assign cursor_y    = cur_y_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fsm_cursor_painter.sv
// Testbench for fsm_cursor_painter on a 4x4 grid with a 4-cycle tick.
// Every expected pixel write is queued when stimulus is applied and popped when px_wr is seen.
module tb_fsm_cursor_painter;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 3;
    localparam int unsigned GW   = 4;
    localparam int unsigned GH   = 4;
    localparam int unsigned TD   = 4;
    localparam int unsigned NPIX = GW * GH;
    localparam logic [DW-1:0] BG = 3'b000;
`ifdef FSM_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          btn_right, btn_left, btn_down, btn_up;
    logic [DW-1:0] color_in;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic [1:0]    cursor_x;
    logic [1:0]    cursor_y;
    logic          busy;

    fsm_cursor_painter #(
        .AW(AW), .DW(DW), .GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_right(btn_right), .btn_left(btn_left), .btn_down(btn_down), .btn_up(btn_up),
        .color_in(color_in),
        .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            phase;   // expected tick-counter value when the write appears, -1 = any
    } wr_t;

    typedef struct {
        logic [3:0]    btn;     // {right, left, down, up}
        logic [DW-1:0] color;
        int            ex;
        int            ey;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[15];
    int   n_checks;
    int   n_fail;
    int   tb_cnt;
    bit   wr_seen;
    int   last_addr;
    int   pos_x;
    int   pos_y;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: mirror the tick counter, then sample outputs on the falling edge.
    task automatic step();
        wr_t e;
        @(posedge clk);
        tb_cnt = rst ? 0 : ((tb_cnt == int'(TD) - 1) ? 0 : tb_cnt + 1);
        @(negedge clk);
        wr_seen = px_wr;
        if (px_wr) begin
            last_addr = int'(mem_px_addr);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write (t=%0t)",
                         mem_px_addr, mem_px_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(mem_px_addr), int'(e.addr));
                check("wr_data", int'(mem_px_data), int'(e.data));
                if (e.phase >= 0) check("wr_latency", tb_cnt, e.phase);
            end
        end
    endtask

    task automatic push_wr(input int addr, input logic [DW-1:0] data, input int phase);
        wr_t e;
        e.addr  = AW'(addr);
        e.data  = data;
        e.phase = phase;
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input logic [DW-1:0] cursor_color);
        for (int a = 0; a < int'(NPIX); a++) push_wr(a, BG, -1);
        push_wr(0, cursor_color, -1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic wait_write(input string name);
        int n;
        wr_seen = 1'b0;
        n = 0;
        while (!wr_seen && n < 20) begin
            step();
            n++;
        end
        check(name, int'(wr_seen), 1);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic check_reset_outputs();
        check("rst_px_wr", int'(px_wr), 0);
        check("rst_addr", int'(mem_px_addr), 0);
        check("rst_data", int'(mem_px_data), 0);
        check("rst_cursor_x", int'(cursor_x), 0);
        check("rst_cursor_y", int'(cursor_y), 0);
        check("rst_busy", int'(busy), 1);
    endtask

    // Hold the buttons until the first write of the move, then release so only one tick moves.
    task automatic do_move(input vec_t v);
        set_btn(v.btn);
        color_in = v.color;
        if (!TRAIL) push_wr(pos_y * int'(GW) + pos_x, BG, 0);
        push_wr(v.ey * int'(GW) + v.ex, v.color, TRAIL ? 0 : 1);
        wait_write("move_start");
        set_btn(4'b0000);
        wait_idle("move_done");
        check("cursor_x", int'(cursor_x), v.ex);
        check("cursor_y", int'(cursor_y), v.ey);
        check("move_queue_empty", exp_q.size(), 0);
        pos_x = v.ex;
        pos_y = v.ey;
    endtask

    initial begin
        int n;
        vec_t v;
        n_checks  = 0;
        n_fail    = 0;
        tb_cnt    = 0;
        wr_seen   = 1'b0;
        last_addr = -1;
        pos_x     = 0;
        pos_y     = 0;

        vecs[0]  = '{4'b1000, 3'b111, 1, 0};
        vecs[1]  = '{4'b1000, 3'b010, 2, 0};
        vecs[2]  = '{4'b1000, 3'b001, 3, 0};
        vecs[3]  = '{4'b1000, 3'b110, 0, 0};   // x wraps right
        vecs[4]  = '{4'b0100, 3'b011, 3, 0};   // x wraps left
        vecs[5]  = '{4'b0010, 3'b100, 3, 1};
        vecs[6]  = '{4'b0010, 3'b101, 3, 2};
        vecs[7]  = '{4'b1000, 3'b111, 0, 2};   // (3,2) + right -> addr 8
        vecs[8]  = '{4'b1101, 3'b010, 1, 2};   // right wins over left and up
        vecs[9]  = '{4'b0001, 3'b001, 1, 1};
        vecs[10] = '{4'b0001, 3'b110, 1, 0};
        vecs[11] = '{4'b0001, 3'b011, 1, 3};   // y wraps up
        vecs[12] = '{4'b0010, 3'b100, 1, 0};   // y wraps down
        vecs[13] = '{4'b0110, 3'b101, 0, 0};   // left wins over down
        vecs[14] = '{4'b0011, 3'b111, 0, 1};   // down wins over up

        rst      = 1'b1;
        color_in = 3'b101;
        set_btn(4'b0000);
        step();
        check_reset_outputs();

        // Power-up clear, then the cursor dot at (0,0).
        push_clear(3'b101);
        rst = 1'b0;
        wait_idle("clear_done");
        check("clear_queue_empty", exp_q.size(), 0);
        check("clear_cursor_x", int'(cursor_x), 0);

        foreach (vecs[i]) do_move(vecs[i]);

        // Ticks with no button held must produce no writes.
        for (int i = 0; i < 12; i++) step();
        check("idle_no_write_busy", int'(busy), 0);
        check("idle_no_write_queue", exp_q.size(), 0);

        // Reset in the middle of a move: the draw is abandoned and the clear restarts.
        set_btn(4'b1000);
        color_in = 3'b011;
        if (TRAIL) push_wr(pos_y * int'(GW) + ((pos_x + 1) % int'(GW)), 3'b011, 0);
        else       push_wr(pos_y * int'(GW) + pos_x, BG, 0);
        wait_write("midmove_start");
        set_btn(4'b0000);
        rst = 1'b1;
        exp_q.delete();
        step();
        check_reset_outputs();
        color_in = 3'b110;
        push_clear(3'b110);
        rst = 1'b0;
        wait_idle("midmove_clear_done");
        check("midmove_queue_empty", exp_q.size(), 0);
        pos_x = 0;
        pos_y = 0;

        // Reset in the middle of the clear at address 7: the clear restarts from address 0.
        rst = 1'b1;
        exp_q.delete();
        step();
        push_clear(3'b110);
        rst = 1'b0;
        last_addr = -1;
        n = 0;
        while (last_addr != 7 && n < 30) begin
            step();
            n++;
        end
        check("midclear_reached_addr7", last_addr, 7);
        rst = 1'b1;
        exp_q.delete();
        step();
        check_reset_outputs();
        push_clear(3'b110);
        rst = 1'b0;
        wait_idle("midclear_clear_done");
        check("midclear_queue_empty", exp_q.size(), 0);

        // Normal moves still work after the aborted clear.
        v = '{4'b1000, 3'b111, 1, 0};
        do_move(v);
        v = '{4'b0001, 3'b010, 1, 3};
        do_move(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
